// File: rtl/riscv_pkg.sv
// Shared processor definitions: datapath width, reset vector, opcodes used by
// decode, and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_RTYPE = 7'd51;
  localparam logic [6:0] OPC_LD    = 7'd3;
  localparam logic [6:0] OPC_SD    = 7'd35;
  localparam logic [6:0] OPC_BEQ   = 7'd99;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the fetch unit's memory request/response channels, decode handshake
// and redirect inputs; master is the fetch unit, slave is its environment.
interface instr_fetch_if import riscv_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) ();

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_err;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, misalign_err,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, misalign_err,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, REQ/WAIT/HOLD fetch FSM and a one-entry
// output buffer feeding decode, with branch redirect and wrong-path discard.
module instr_fetch import riscv_pkg::*; #(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.mem_req_valid = !rst && (state_q == REQ);
  assign bus.mem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign bus.instr_valid   = !rst && (state_q == HOLD);
  assign bus.instr         = instr_q;
  assign bus.instr_pc      = instr_pc_q;
  assign bus.misalign_err  = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Redirect overrides every other transition; a request already accepted
  // under the old PC is marked for discard via drop.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = misalign_q;

    if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end

    case (state_q)
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_pc_aligned;
          if (bus.mem_req_ready) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end else if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_pc_aligned;
          if (bus.mem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.mem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d    = bus.mem_rsp_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + XLEN'(4);
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_pc_aligned;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.mem_rsp_valid |-> (state_q == WAIT));

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit: the producer side of the `instr` word that the processor's decode stage consumes.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel with a separate response channel.
- Presents each fetched word plus its PC to decode over a valid/ready handshake.
- Accepts PC redirects (branch taken, e.g. BEQ) from execute and discards wrong-path fetches.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- mem_req_valid  output  1  read request to instruction memory.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  XLEN  word-aligned byte address of request.
- mem_rsp_valid  input  1  response data valid.
- mem_rsp_data  input  XLEN  fetched instruction word.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode accepts instruction this cycle.
- instr  output  XLEN  instruction word to decode.
- instr_pc  output  XLEN  PC of instr.
- redirect_valid  input  1  load new PC (taken branch).
- redirect_pc  input  XLEN  branch target.
- misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst high at an edge):
  - state=REQ, pc=RESET_PC, drop=0, instr=0, instr_pc=0, misalign_err=0.
  - mem_req_valid and instr_valid are forced 0 combinationally while rst is high.
- Instruction memory shares rst and discards any outstanding response on reset. No response arrives for a request issued before reset.
- At most one memory request outstanding. Responses return in order, at least 1 cycle after acceptance.
- REQ state:
  - mem_req_valid=1, mem_req_addr=pc.
  - On mem_req_ready: go to WAIT.
- WAIT state:
  - mem_req_valid=0.
  - On mem_rsp_valid with drop=1: discard data, set drop=0, go to REQ.
  - On mem_rsp_valid with drop=0: instr<=mem_rsp_data, instr_pc<=pc, pc<=pc+4, go to HOLD.
- HOLD state:
  - instr_valid=1; instr and instr_pc are stable until the handshake completes.
  - On instr_ready: go to REQ.
  - Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with 1-cycle memory).
- PC arithmetic:
  - pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
  - mem_req_addr[1:0] is always 0.
- Redirect (redirect_valid=1): highest priority over every other transition in the same cycle.
  - pc <= redirect_pc with bits [1:0] cleared. If redirect_pc[1:0]!=0, misalign_err<=1 (cleared only by rst).
  - REQ, no handshake this cycle: stay in REQ. mem_req_addr shows the new pc the next cycle; memory must tolerate an address change while valid, which happens only on redirect.
  - REQ with handshake this cycle: the old-address request is in flight. Go to WAIT with drop=1.
  - WAIT, no response this cycle: drop<=1, stay in WAIT.
  - WAIT, response this cycle: discard it, drop=0, go to REQ.
  - HOLD without instr_ready: discard the buffered instr; instr_valid=0 next cycle; go to REQ.
  - HOLD with instr_ready: the handshake completes (decode took the old instruction), then go to REQ with the new pc.
- A redirect during a cycle with drop already 1 keeps drop=1. Only one response is outstanding, so a single drop bit suffices.
- mem_rsp_valid outside WAIT is a protocol violation and is ignored. Add an assertion in simulation.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and RESET_PC defaults.
  - Opcode constants used by decode: 51 (R-type), 3 (LD), 35 (SD), 99 (BEQ).
  - NOP encoding 32'h0000_0013.
  - fetch_state_t enum {REQ, WAIT, HOLD}.
- No sub-module needed: PC register, 3-state FSM and 1-entry output buffer live in instr_fetch.
- The bench provides a behavioural instruction-memory model with configurable response latency and ready stalls.

Test Plan:
- Reset, then 1-cycle memory and instr_ready=1: requests at 0x0, 0x4, 0x8. instr_pc sequence 0x0, 0x4, 0x8 with matching words. instr_valid pulses every 3 cycles.
- mem_req_ready low for 5 cycles at pc=0x10: mem_req_valid stays 1 and mem_req_addr holds 0x10 throughout. Exactly one request is accepted.
- instr_ready low for 4 cycles in HOLD: instr and instr_pc are stable. No new mem_req_valid until the handshake completes.
- redirect_pc=0x100 while in WAIT for 0x20 (3-cycle memory): the 0x20 response is discarded. The next request is 0x100 and the next instr_pc is 0x100.
- redirect_pc=0x102 in REQ: the next mem_req_addr is 0x100 and misalign_err=1. misalign_err stays 1 until rst.
- Simultaneous instr_ready and redirect_valid (target 0x40) in HOLD with instr_pc=0x8: the 0x8 instruction is counted as consumed. The next request is 0x40.
- rst asserted mid-WAIT: the next cycle has all outputs 0. After rst drops, the first request is RESET_PC.
